vx_tcu_drl_term_accum: RTL and testbench

//  Consumer end of the TCU DRL shared-multiplier interface. Takes the TCK+1 per-lane 25-bit

---
 rtl/vx_tcu_drl_term_accum_pkg.sv | 29 ++
 rtl/vx_tcu_drl_norm_round.sv | 59 +++++
 rtl/vx_tcu_drl_term_accum.sv | 143 ++++++++++++++
 tb/tb_vx_tcu_drl_term_accum.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/vx_tcu_drl_term_accum_pkg.sv
// Shared constants and types for the TCU DRL term accumulator (format IDs, term layout,
// accumulator width helper).
package vx_tcu_drl_term_accum_pkg;

  localparam logic [3:0] TCU_FP32_ID = 4'd0;
  localparam logic [3:0] TCU_FP16_ID = 4'd1;
  localparam logic [3:0] TCU_BF16_ID = 4'd2;
  localparam logic [3:0] TCU_I8_ID   = 4'd9;
  localparam logic [3:0] TCU_U8_ID   = 4'd10;

  localparam int TCU_DRL_GW = 3;

  typedef struct packed {
    logic        sign;
    logic [23:0] mag;
  } tcu_drl_term_t;

  typedef struct packed {
    logic is_nan;
    logic is_inf;
    logic sign;
  } fedp_class_t;

  // Aligned magnitude + guard bits, growth for tck+1 addends, and a sign bit.
  function automatic int tcu_drl_acc_w(input int tck, input int gw);
    return 24 + gw + $clog2(tck + 1) + 1;
  endfunction

endpackage

// File: rtl/vx_tcu_drl_norm_round.sv
// Final-stage combinational normalize/round/pack of the signed accumulator into fp32.
// Rounding is RNE when TCU_DRL_RNE_EN is defined, truncation otherwise.
module vx_tcu_drl_norm_round
  import vx_tcu_drl_term_accum_pkg::*;
#(
  parameter int AW = 31,
  parameter int GW = 3
) (
  input  logic [AW-1:0] acc,
  input  logic [7:0]    max_exp,
  input  fedp_class_t   spc,
  output logic [31:0]   result
);

  logic          sign;
  logic [AW-1:0] mag;
  logic [AW-1:0] norm;
  logic [7:0]    lead;
  logic [22:0]   mant;
  int            exp_pre;
  int            exp_fin;
`ifdef TCU_DRL_RNE_EN
  logic          guard;
  logic          rs;
  logic [23:0]   mant_inc;
`else
  logic          unused_low;
`endif

  always_comb begin
    sign = acc[AW-1];
    mag  = sign ? (~acc + 1'b1) : acc;
    lead = '0;
    for (int i = 0; i < AW; i++) begin
      if (mag[i]) lead = 8'(i);
    end
    // Leading one moves to the top bit; the hidden one is dropped from the mantissa.
    norm    = mag << (AW - 1 - int'(lead));
    mant    = norm[AW-2 -: 23];
    exp_pre = int'(max_exp) + int'(lead) - (22 + GW);
    exp_fin = exp_pre;
`ifdef TCU_DRL_RNE_EN
    guard    = norm[AW-25];
    rs       = |norm[AW-26:0];
    mant_inc = {1'b0, mant} + 24'(guard & (rs | mant[0]));
    if (mant_inc[23]) exp_fin = exp_pre + 1;
    mant     = mant_inc[22:0];
`else
    unused_low = ^norm[AW-25:0];
`endif
    if (spc.is_nan)          result = 32'h7FC0_0000;
    else if (spc.is_inf)     result = {spc.sign, 8'hFF, 23'h0};
    else if (mag == '0)      result = 32'h0;
    else if (exp_pre <= 0)   result = {sign, 31'h0};
    else if (exp_fin >= 255) result = {sign, 8'hFF, 23'h0};
    else                     result = {sign, exp_fin[7:0], mant};
  end

endmodule

// File: rtl/vx_tcu_drl_term_accum.sv
// TCU DRL term accumulator: align (S0), reduce (S1), normalize/round (S2), elastic valid/ready.
// Float rounding mode selected by TCU_DRL_RNE_EN (RNE when defined, truncation otherwise).
module vx_tcu_drl_term_accum
  import vx_tcu_drl_term_accum_pkg::*;
#(
  parameter int N   = 2,
  parameter int TCK = 2 * N,
  parameter int GW  = TCU_DRL_GW
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          fmt_s,
  input  logic [TCK:0][24:0]  y,
  input  logic [TCK:0][7:0]   align_sh,
  input  logic [7:0]          max_exp,
  input  logic                spc_nan,
  input  logic                spc_inf,
  input  logic                spc_sign,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         result,
  output logic [3:0]          out_fmt
);

  localparam int NT = TCK + 1;
  localparam int AW = tcu_drl_acc_w(TCK, GW);
  localparam int PW = 24 + GW;
  localparam int SW = (AW > 32) ? AW : 32;

  // Float: guard-extend, right shift with sticky, then negate. Int: sign-extend.
  function automatic logic [SW-1:0] align_term(input tcu_drl_term_t t, input logic [7:0] sh,
                                               input logic is_int);
    logic [PW-1:0] placed;
    logic [PW-1:0] shifted;
    logic [PW-1:0] lost;
    logic [SW-1:0] ext;
    if (is_int) return {{(SW-25){t.sign}}, t};
    placed = {t.mag, {GW{1'b0}}};
    if (sh >= 8'(PW)) begin
      shifted = {{(PW-1){1'b0}}, |t.mag};
    end else begin
      lost    = placed & ~({PW{1'b1}} << sh);
      shifted = (placed >> sh) | PW'(|lost);
    end
    ext = SW'(shifted);
    return t.sign ? (~ext + 1'b1) : ext;
  endfunction

  // Handshake: a stage loads whenever the stage after it is empty or draining this cycle;
  // in_ready and every stage enable chain combinationally back from out_ready.
  logic ready0, ready1, ready2;
  logic v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
  logic [SW-1:0] term_q [NT];
  logic [SW-1:0] term_d [NT];
  logic [SW-1:0] term_sum;
  logic [SW-1:0] sum1_q, sum1_d;
  logic [3:0]    fmt0_q, fmt0_d, fmt1_q, fmt1_d, fmt2_q, fmt2_d;
  logic [7:0]    exp0_q, exp0_d, exp1_q, exp1_d;
  fedp_class_t   spc0_q, spc0_d, spc1_q, spc1_d;
  logic [31:0]   res2_q, res2_d;
  logic [31:0]   float_res;

  assign ready2 = !v2_q || out_ready;
  assign ready1 = !v1_q || ready2;
  assign ready0 = !v0_q || ready1;

  always_comb begin
    v0_d = v0_q;  fmt0_d = fmt0_q;  exp0_d = exp0_q;  spc0_d = spc0_q;  term_d = term_q;
    v1_d = v1_q;  fmt1_d = fmt1_q;  exp1_d = exp1_q;  spc1_d = spc1_q;  sum1_d = sum1_q;
    v2_d = v2_q;  fmt2_d = fmt2_q;  res2_d = res2_q;
    term_sum = '0;
    for (int i = 0; i < NT; i++) term_sum = term_sum + term_q[i];

    if (ready0) begin
      v0_d = in_valid;
      if (in_valid) begin
        fmt0_d = fmt_s;
        exp0_d = max_exp;
        spc0_d = {spc_nan, spc_inf, spc_sign};
        for (int i = 0; i < NT; i++) term_d[i] = align_term(y[i], align_sh[i], fmt_s[3]);
      end
    end
    if (ready1) begin
      v1_d = v0_q;
      if (v0_q) begin
        fmt1_d = fmt0_q;
        exp1_d = exp0_q;
        spc1_d = spc0_q;
        sum1_d = term_sum;
      end
    end
    if (ready2) begin
      v2_d = v1_q;
      if (v1_q) begin
        fmt2_d = fmt1_q;
        res2_d = fmt1_q[3] ? sum1_q[31:0] : float_res;
      end
    end
  end

  vx_tcu_drl_norm_round #(.AW(AW), .GW(GW)) u_norm_round (
    .acc     (sum1_q[AW-1:0]),
    .max_exp (exp1_q),
    .spc     (spc1_q),
    .result  (float_res)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      v0_q   <= 1'b0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      fmt2_q <= '0;
      res2_q <= '0;
    end else begin
      v0_q   <= v0_d;
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      fmt2_q <= fmt2_d;
      res2_q <= res2_d;
    end
  end

  // Intermediate payload needs no reset; its valid bit qualifies it.
  always_ff @(posedge clk) begin
    term_q <= term_d;
    fmt0_q <= fmt0_d;
    exp0_q <= exp0_d;
    spc0_q <= spc0_d;
    sum1_q <= sum1_d;
    fmt1_q <= fmt1_d;
    exp1_q <= exp1_d;
    spc1_q <= spc1_d;
  end

  assign in_ready  = ready0;
  assign out_valid = v2_q;
  assign result    = res2_q;
  assign out_fmt   = fmt2_q;

endmodule

// File: tb/tb_vx_tcu_drl_term_accum.sv
// Directed + randomized bench for vx_tcu_drl_term_accum with an in-order result scoreboard.
// Rounding expectations follow TCU_DRL_RNE_EN.
module tb_vx_tcu_drl_term_accum;
  import vx_tcu_drl_term_accum_pkg::*;

  localparam int NT = 5;
  localparam logic [24:0] ONE     = {1'b0, 24'h400000};
  localparam logic [24:0] NEG_ONE = {1'b1, 24'h400000};
  localparam logic [24:0] FRAC1   = {1'b0, 24'h7FFFFF};
`ifdef TCU_DRL_RNE_EN
  localparam logic [31:0] EXP_TIE_ODD = 32'h3F80_0002;
  localparam logic [31:0] EXP_ABOVE   = 32'h3F80_0001;
  localparam logic [31:0] EXP_CARRY   = 32'h4000_0000;
  localparam logic [31:0] EXP_CARRY_H = 32'h7F80_0000;
`else
  localparam logic [31:0] EXP_TIE_ODD = 32'h3F80_0001;
  localparam logic [31:0] EXP_ABOVE   = 32'h3F80_0000;
  localparam logic [31:0] EXP_CARRY   = 32'h3FFF_FFFF;
  localparam logic [31:0] EXP_CARRY_H = 32'h7F7F_FFFF;
`endif

  // clock / reset / signals
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [3:0] fmt_s = '0;
  logic [NT-1:0][24:0] y = '0;
  logic [NT-1:0][7:0] align_sh = '0;
  logic [7:0] max_exp = '0;
  logic spc_nan = 1'b0, spc_inf = 1'b0, spc_sign = 1'b0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [31:0] result;
  logic [3:0] out_fmt;

  int checks = 0;
  int errors = 0;
  logic [35:0] exp_q[$];

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  vx_tcu_drl_term_accum dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .fmt_s(fmt_s),
    .y(y), .align_sh(align_sh), .max_exp(max_exp), .spc_nan(spc_nan), .spc_inf(spc_inf),
    .spc_sign(spc_sign), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .out_fmt(out_fmt)
  );

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [NT-1:0][24:0] mk(input logic [24:0] a, input logic [24:0] b = '0,
      input logic [24:0] c = '0, input logic [24:0] d = '0, input logic [24:0] e = '0);
    return {e, d, c, b, a};
  endfunction

  function automatic logic [NT-1:0][7:0] mksh(input logic [7:0] a, input logic [7:0] b = '0,
      input logic [7:0] c = '0);
    return {8'd0, 8'd0, c, b, a};
  endfunction

  // driver: present one beat, hold until accepted (bounded)
  task automatic send(input logic [3:0] f, input logic [NT-1:0][24:0] ty,
                      input logic [NT-1:0][7:0] tsh, input logic [7:0] me,
                      input logic [2:0] spc, input logic [31:0] exp_res);
    int n;
    exp_q.push_back({f, exp_res});
    fmt_s = f; y = ty; align_sh = tsh; max_exp = me;
    {spc_nan, spc_inf, spc_sign} = spc;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) check("send_accept", in_ready, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 36'(exp_q.size()), 36'd0);
    @(posedge clk);
    #1;
  endtask

  // scoreboard: compare every accepted output against the head of the expected queue
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_out: observed %h expected none", {out_fmt, result});
      end else begin
        check("result", {out_fmt, result}, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [NT-1:0][24:0] rv;
    logic [31:0] rsum;
    logic [31:0] held;

    // reset state
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, 32'h0);
    check("rst_out_fmt", out_fmt, 4'h0);
    reset = 1'b1;
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // 1.0 with 3-cycle latency check
    send(TCU_FP16_ID, mk(ONE), mksh(0), 8'd127, 3'b000, 32'h3F80_0000);
    @(posedge clk); #1;
    check("lat_cycle2", out_valid, 1'b0);
    @(posedge clk); #1;
    check("lat_cycle3", out_valid, 1'b1);
    drain();

    // float patterns
    send(TCU_FP16_ID, mk(ONE, NEG_ONE), mksh(0, 0), 8'd127, 3'b000, 32'h0000_0000);
    send(TCU_FP16_ID, mk(NEG_ONE), mksh(0), 8'd127, 3'b000, 32'hBF80_0000);
    send(TCU_FP16_ID, mk({1'b0, 24'h600000}, ONE), mksh(0, 2), 8'd127, 3'b000, 32'h3FE0_0000);
    send(TCU_FP16_ID, mk(ONE, 25'd0), mksh(0, 200), 8'd127, 3'b000, 32'h3F80_0000);
    send(TCU_FP16_ID, mk({1'b1, 24'h000001}), mksh(0), 8'd10, 3'b000, 32'h8000_0000);
    send(TCU_FP16_ID, mk(ONE, ONE), mksh(0, 0), 8'd254, 3'b000, 32'h7F80_0000);
    // rounding: tie-even, tie-odd, above-half via sticky, mantissa carry
    send(TCU_FP16_ID, mk(ONE, ONE), mksh(0, 24), 8'd127, 3'b000, 32'h3F80_0000);
    send(TCU_FP16_ID, mk(ONE, ONE, ONE), mksh(0, 24, 23), 8'd127, 3'b000, EXP_TIE_ODD);
    send(TCU_FP16_ID, mk(ONE, ONE, ONE), mksh(0, 24, 30), 8'd127, 3'b000, EXP_ABOVE);
    send(TCU_FP16_ID, mk(FRAC1, ONE, ONE), mksh(0, 23, 24), 8'd127, 3'b000, EXP_CARRY);
    send(TCU_FP16_ID, mk(FRAC1, ONE, ONE), mksh(0, 23, 24), 8'd254, 3'b000, EXP_CARRY_H);
    drain();

    // int patterns
    send(TCU_I8_ID, mk(25'h1FFFFFF, 25'd5), '0, 8'd0, 3'b000, 32'h0000_0004);
    send(TCU_I8_ID, mk(25'hFFFFFF, 25'hFFFFFF, 25'hFFFFFF, 25'hFFFFFF, 25'hFFFFFF), '0, 8'd0,
         3'b000, 32'h04FF_FFFB);
    send(TCU_I8_ID, mk(25'h1000000, 25'h1000000, 25'h1000000, 25'h1000000, 25'h1000000), '0,
         8'd0, 3'b000, 32'hFB00_0000);
    for (int k = 0; k < 8; k++) begin
      rsum = '0;
      for (int j = 0; j < NT; j++) begin
        rv[j] = 25'($urandom_range(0, 32'h1FF_FFFF));
        rsum = rsum + {{7{rv[j][24]}}, rv[j]};
      end
      send(TCU_I8_ID, rv, mksh(8'($urandom_range(0, 255))), 8'($urandom_range(0, 255)), 3'b000,
           rsum);
    end
    drain();

    // specials (int format ignores special flags)
    send(TCU_FP16_ID, mk(ONE), mksh(0), 8'd127, 3'b100, 32'h7FC0_0000);
    send(TCU_FP16_ID, mk(ONE), mksh(0), 8'd127, 3'b011, 32'hFF80_0000);
    send(TCU_FP16_ID, mk(ONE), mksh(0), 8'd127, 3'b111, 32'h7FC0_0000);
    drain();

    // backpressure: 4 beats while out_ready is low
    out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 4; k++)
          send(TCU_I8_ID, mk(25'(k * 7 + 1)), '0, 8'd0, 3'b000, 32'(k * 7 + 1));
      end
      begin
        repeat (4) @(negedge clk);
        check("bp_in_ready_low", in_ready, 1'b0);
        check("bp_out_valid", out_valid, 1'b1);
        held = result;
        repeat (2) begin
          @(negedge clk);
          check("bp_result_stable", result, held);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // reset with two beats in flight
    send(TCU_I8_ID, mk(25'd11), '0, 8'd0, 3'b000, 32'd11);
    send(TCU_I8_ID, mk(25'd22), '0, 8'd0, 3'b000, 32'd22);
    reset = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("post_rst_idle", out_valid, 1'b0);
    end
    send(TCU_FP16_ID, mk(ONE), mksh(0), 8'd128, 3'b000, 32'h4000_0000);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
